// File: rtl/cnn_pkg.sv
// Shared constants for the 3x3 convolution datapath: default widths, kernel
// geometry and the rd_row phase encoding used by the pixel read stream.
package cnn_pkg;

  localparam int unsigned CNN_PIX_W = 8;
  localparam int unsigned CNN_WGT_W = 8;
  localparam int unsigned CNN_OUT_W = CNN_PIX_W + CNN_WGT_W + 1 + 4;

  // Kernel edge length and number of taps
  localparam int unsigned K     = 3;
  localparam int unsigned NTAPS = K * K;

  // rd_row phase encoding
  localparam logic [1:0] ROW0     = 2'd0;
  localparam logic [1:0] ROW1     = 2'd1;
  localparam logic [1:0] ROW2     = 2'd2;
  localparam logic [1:0] ROW_IDLE = 2'd3;

endpackage

// File: rtl/mac9_pipe.sv
// Two-stage 9-tap multiply-accumulate: S1 holds the products, S2 holds the
// summed result. Both stages stall under output back-pressure.
module mac9_pipe
  import cnn_pkg::*;
#(
  parameter int unsigned PIX_W = CNN_PIX_W,
  parameter int unsigned WGT_W = CNN_WGT_W,
  parameter int unsigned OUT_W = CNN_OUT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              launch,
  input  logic [NTAPS-1:0][PIX_W-1:0]       pix,
  input  logic [NTAPS-1:0][WGT_W-1:0]       wgt,
  input  logic                              out_ready,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic signed [OUT_W-1:0]           conv_out
);

  localparam int unsigned PROD_W = PIX_W + WGT_W + 1;

  logic                               s1_valid_q;
  logic [NTAPS-1:0][PROD_W-1:0]       prod_q;
  logic [NTAPS-1:0][PROD_W-1:0]       prod_d;
  logic signed [OUT_W-1:0]            sum_d;
  logic                               out_valid_q;
  logic signed [OUT_W-1:0]            conv_q;
  logic                               s2_load;

  assign s2_load   = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign out_valid = out_valid_q;
  assign conv_out  = conv_q;

  // Products of zero-extended pixels with signed weights
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'($signed(wgt[i]));
    end
  end

  // Sign-extended sum of the registered products
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      sum_d = sum_d + OUT_W'($signed(prod_q[i]));
    end
  end

  // S1/S2 registers; S1 only moves when S2 can take its contents
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      conv_q      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= launch;
        if (launch) prod_q <= prod_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) conv_q <= sum_d;
      end
    end
  end

endmodule

// File: rtl/conv3x3_window_mac.sv
// Sliding 3x3 window assembly from per-row pixel reads, kernel weight register
// file, and hand-off of each full window to the MAC pipeline.
module conv3x3_window_mac
  import cnn_pkg::*;
#(
  parameter int unsigned PIX_W = CNN_PIX_W,
  parameter int unsigned WGT_W = CNN_WGT_W,
  parameter int unsigned OUT_W = CNN_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_start,
  input  logic                    rd_valid,
  input  logic [1:0]              rd_row,
  input  logic [PIX_W-1:0]        rd_data,
  input  logic                    rd_zero,
  output logic                    in_ready,
  input  logic                    w_we,
  input  logic [3:0]              w_idx,
  input  logic [WGT_W-1:0]        w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] conv_out
);

  // The oldest window column is taken from hist_q[0] at launch time, so only
  // the two most recent completed columns need storing.
  logic [1:0][K-1:0][PIX_W-1:0]   hist_q, hist_d;
  logic [1:0][PIX_W-1:0]          col_buf_q, col_buf_d;
  logic [1:0]                     exp_row_q, exp_row_d, exp_row_eff;
  logic [1:0]                     col_cnt_q, col_cnt_d, col_cnt_eff;
  logic [NTAPS-1:0][WGT_W-1:0]    wgt_q;

  logic                           accept;
  logic [PIX_W-1:0]               pix_in;
  logic                           col_done;
  logic                           launch;
  logic [K-1:0][PIX_W-1:0]        new_col;
  logic [NTAPS-1:0][PIX_W-1:0]    mac_pix;

  assign pix_in = rd_zero ? '0 : rd_data;
  assign accept = rd_valid && in_ready && (rd_row != ROW_IDLE);

  // line_start clears first so a same-cycle sample starts the new line
  assign exp_row_eff = line_start ? ROW0 : exp_row_q;
  assign col_cnt_eff = line_start ? 2'd0 : col_cnt_q;

  assign new_col = {pix_in, col_buf_q[1], col_buf_q[0]};

  // Column assembly and window shift
  always_comb begin
    hist_d    = hist_q;
    col_buf_d = col_buf_q;
    exp_row_d = exp_row_eff;
    col_cnt_d = col_cnt_eff;
    col_done  = 1'b0;
    if (accept) begin
      case (rd_row)
        ROW0: begin
          col_buf_d[0] = pix_in;
          exp_row_d    = ROW1;
        end
        ROW1: begin
          if (exp_row_eff == ROW1) begin
            col_buf_d[1] = pix_in;
            exp_row_d    = ROW2;
          end else begin
            exp_row_d = ROW0;
          end
        end
        ROW2: begin
          exp_row_d = ROW0;
          col_done  = (exp_row_eff == ROW2);
        end
        default: ;
      endcase
    end
    if (col_done) begin
      hist_d[0] = hist_q[1];
      hist_d[1] = new_col;
      col_cnt_d = (col_cnt_eff == 2'd3) ? 2'd3 : col_cnt_eff + 2'd1;
    end
  end

  assign launch = col_done && (col_cnt_d == 2'd3);

  // Row-major tap vector of the window as it stands after this completion
  always_comb begin
    mac_pix = '0;
    for (int r = 0; r < int'(K); r++) begin
      mac_pix[K*r+0] = hist_q[0][r];
      mac_pix[K*r+1] = hist_q[1][r];
      mac_pix[K*r+2] = new_col[r];
    end
  end

  // Window, column buffer, row expectation and column count state
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      col_buf_q <= '0;
      exp_row_q <= ROW0;
      col_cnt_q <= 2'd0;
    end else begin
      hist_q    <= hist_d;
      col_buf_q <= col_buf_d;
      exp_row_q <= exp_row_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Kernel register file; indices above 8 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        if (w_we && (w_idx == 4'(i))) wgt_q[i] <= w_data;
      end
    end
  end

  mac9_pipe #(
    .PIX_W (PIX_W),
    .WGT_W (WGT_W),
    .OUT_W (OUT_W)
  ) u_mac9_pipe (
    .clk       (clk),
    .rst       (rst),
    .launch    (launch),
    .pix       (mac_pix),
    .wgt       (wgt_q),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .conv_out  (conv_out)
  );

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Self-checking bench: directed scenarios plus randomized lines, checked
// against a column-list reference model of the 3x3 convolution.
module tb_conv3x3_window_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               line_start;
  logic               rd_valid;
  logic [1:0]         rd_row;
  logic [7:0]         rd_data;
  logic               rd_zero;
  logic               in_ready;
  logic               w_we;
  logic [3:0]         w_idx;
  logic [7:0]         w_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [20:0] conv_out;

  conv3x3_window_mac #(
    .PIX_W (8),
    .WGT_W (8),
    .OUT_W (21)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .rd_valid   (rd_valid),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .rd_zero    (rd_zero),
    .in_ready   (in_ready),
    .w_we       (w_we),
    .w_idx      (w_idx),
    .w_data     (w_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .conv_out   (conv_out)
  );

  always #5 clk = ~clk;

  typedef int col_t[3];

  int     checks  = 0;
  int     errors  = 0;
  int     results = 0;
  bit     rnd_bp  = 1'b0;
  int     wm[9];
  col_t   cols[$];
  longint exp_q[$];

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Model: convolution of the last three completed columns of the line
  task automatic model_col(input int a, input int b, input int c);
    col_t   col;
    longint s = 0;
    int     n;
    col = '{a, b, c};
    cols.push_back(col);
    n = cols.size();
    if (n >= 3) begin
      for (int r = 0; r < 3; r++)
        for (int cc = 0; cc < 3; cc++)
          s += longint'(wm[3*r+cc]) * longint'(cols[n-3+cc][r]);
      exp_q.push_back(s);
    end
  endtask

  // Scoreboard on every output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      results++;
      if (exp_q.size() == 0) check("unexpected_result", longint'(exp_q.size()), 1);
      else check("conv_out", longint'(conv_out), exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] row, input int data, input bit zero);
    bit ok = 1'b0;
    int n  = 0;
    rd_valid = 1'b1;
    rd_row   = row;
    rd_data  = data[7:0];
    rd_zero  = zero;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    rd_valid = 1'b0;
    if (!ok) check("in_ready_timeout", longint'(n), 0);
  endtask

  task automatic send_col(input int a, input int b, input int c, input bit [2:0] zm);
    send(2'd0, a, zm[0]);
    send(2'd1, b, zm[1]);
    send(2'd2, c, zm[2]);
    model_col(zm[0] ? 0 : a, zm[1] ? 0 : b, zm[2] ? 0 : c);
  endtask

  task automatic rand_col();
    bit [2:0] zm;
    zm = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
    send_col($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), zm);
  endtask

  task automatic wr_w(input int idx, input int val);
    w_we   = 1'b1;
    w_idx  = idx[3:0];
    w_data = val[7:0];
    @(posedge clk);
    #1;
    w_we = 1'b0;
    if (idx < 9) wm[idx] = val;
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < 9; i++) wr_w(i, val);
  endtask

  task automatic rand_weights();
    for (int i = 0; i < 9; i++) wr_w(i, int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic new_line();
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    cols.delete();
  endtask

  initial begin
    int r0;
    rst = 1'b1; line_start = 1'b0; rd_valid = 1'b0; rd_row = 2'd3; rd_data = '0;
    rd_zero = 1'b0; w_we = 1'b0; w_idx = '0; w_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) wm[i] = 0;
    idle(2);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_conv_out", longint'(conv_out), 0);
    rst = 1'b0;

    // Identity kernel and first-result latency
    wr_w(4, 1);
    new_line();
    send_col(10, 20, 30, 3'b000);
    send_col(40, 50, 60, 3'b000);
    send_col(70, 80, 90, 3'b000);
    check("lat_early", longint'(out_valid), 0);
    idle(1);
    check("lat_rise", longint'(out_valid), 1);
    check("identity", longint'(conv_out), 50);
    idle(2);

    // All-ones with a padded column, then full negative weights
    set_all(1);
    new_line();
    send_col(255, 255, 255, 3'b111);
    send_col(255, 255, 255, 3'b000);
    send_col(255, 255, 255, 3'b000);
    idle(3);
    check("pad_sum", longint'(conv_out), 1530);
    set_all(-128);
    new_line();
    for (int i = 0; i < 3; i++) send_col(255, 255, 255, 3'b000);
    idle(3);
    check("wide_neg", longint'(conv_out), -293760);

    // Streaming six columns; out-of-range weight index must be ignored
    rand_weights();
    wr_w(12, 77);
    new_line();
    r0 = results;
    for (int i = 0; i < 6; i++) rand_col();
    idle(4);
    check("stream_count", longint'(results - r0), 4);

    // Back-pressure: hold output, fill S1, then release
    new_line();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rand_col();
    idle(3);
    check("bp_valid", longint'(out_valid), 1);
    check("bp_hold0", longint'(conv_out), exp_q[0]);
    rand_col();
    idle(1);
    check("bp_in_ready", longint'(in_ready), 0);
    idle(3);
    check("bp_hold1", longint'(conv_out), exp_q[0]);
    check("bp_queued", longint'(exp_q.size()), 2);
    out_ready = 1'b1;
    rand_col();
    rand_col();
    idle(4);
    check("bp_drained", longint'(exp_q.size()), 0);

    // Out-of-order rows and mid-window line_start
    set_all(0);
    wr_w(4, 1);
    new_line();
    r0 = results;
    send(2'd0, 5, 1'b0);
    send(2'd2, 6, 1'b0);
    rand_col();
    rand_col();
    idle(3);
    check("ooo_no_result", longint'(results - r0), 0);
    new_line();
    rand_col();
    rand_col();
    idle(3);
    check("ls_no_result", longint'(results - r0), 0);
    rand_col();
    idle(4);
    check("ls_one_result", longint'(results - r0), 1);

    // Reset with both pipeline stages full
    rand_weights();
    new_line();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rand_col();
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    cols.delete();
    for (int i = 0; i < 9; i++) wm[i] = 0;
    check("rst_mid_valid", longint'(out_valid), 0);
    check("rst_mid_ready", longint'(in_ready), 1);
    r0 = results;
    out_ready = 1'b1;
    idle(3);
    check("rst_no_stale", longint'(results - r0), 0);
    for (int i = 0; i < 3; i++) rand_col();
    idle(4);
    check("rst_zero_wgt", longint'(conv_out), 0);

    // Randomized lines with random back-pressure
    rnd_bp = 1'b1;
    for (int l = 0; l < 6; l++) begin
      rand_weights();
      new_line();
      for (int i = 0; i < int'($urandom_range(3, 7)); i++) rand_col();
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    idle(6);
    check("final_drained", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_mac.md
Name: conv3x3_window_mac

Overview:
- Consumer stage directly downstream of the padded-address generator and the image RAM.
- Takes per-coordinate pixel reads (phase 0/1/2 = rows j, j+1, j+2 of one column, zero-forced in the padding region) and assembles them into a sliding 3x3 window.
- Multiplies the window by a loadable signed 3x3 kernel and emits one convolution sum per window position through a valid/ready output.

Parameters:
- PIX_W, 8, unsigned pixel width.
- WGT_W, 8, signed kernel weight width.
- OUT_W, 21, signed result width; must equal PIX_W+WGT_W+1+4.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- line_start  in  1  pulse; clears the window column count at the start of a new output row.
- rd_valid  in  1  rd_* fields carry a pixel sample this cycle.
- rd_row  in  2  phase of the sample: 0/1/2 = window row; 3 = idle phase, ignored.
- rd_data  in  PIX_W  pixel from the image RAM, one cycle after the address.
- rd_zero  in  1  sample lies in the padding region; treated as 0 regardless of rd_data.
- in_ready  out  1  block can accept a sample this cycle.
- w_we  in  1  kernel weight write strobe.
- w_idx  in  4  weight index 0..8, row-major (idx = 3*row + col).
- w_data  in  WGT_W  signed weight.
- out_valid  out  1  conv_out holds a result.
- out_ready  in  1  downstream accepts the result.
- conv_out  out  OUT_W  signed 3x3 sum.

Behaviour:
- Reset: in_ready=1, out_valid=0, conv_out=0. Window, column buffer, column count, pipeline valids and all 9 weights are cleared to 0. Reset mid-operation discards any in-flight window with no partial output.
- A sample is accepted when rd_valid && in_ready && rd_row!=3. Samples with rd_row==3 are ignored.
- Column assembly:
  - row 0 is stored to col_buf[0]; expect row 1.
  - row 1 is accepted only if expected; otherwise the sample is dropped and the expectation returns to row 0.
  - row 2 completes the column.
  - A row 0 arriving while row 1 or row 2 is expected restarts the column.
- On column complete: the window shifts left (col0<=col1, col1<=col2, col2<=new column) and col_cnt saturates at 3.
- A MAC is launched on every column completion after which col_cnt==3, i.e. the 3rd, 4th, ... column of a line.
- line_start: col_cnt<=0 and the row expectation returns to 0. If a sample is accepted in the same cycle, it is processed as the first sample after the clear.
- Arithmetic:
  - Pixel is zero-extended to PIX_W+1 signed; product width is PIX_W+WGT_W+1.
  - The 9 products are summed sign-extended to OUT_W; no saturation, no overflow possible.
- Pipeline:
  - S1 registers the 9 products; S2 registers the sum into conv_out / out_valid.
  - Latency: out_valid rises 2 cycles after the cycle the row-2 sample is accepted.
- Handshake:
  - The output register holds while out_valid && !out_ready.
  - S2 loads when the output is empty or being drained.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s2_load (the combinational term on out_ready is allowed).
  - Back-to-back results at one per cycle are sustainable with out_ready held high.
- Weights:
  - A write takes effect for MACs launched in the cycle after w_we. Products already in S1 are unaffected.
  - w_idx>8 is ignored.
  - A write in the same cycle as a launch does not affect that launch.

Decomposition:
- Shared package cnn_pkg holds:
  - PIX_W, WGT_W and OUT_W defaults;
  - kernel size constant K=3;
  - the rd_row encoding constants ROW0/ROW1/ROW2/ROW_IDLE.
- One sub-module, mac9_pipe: S1/S2 product and sum registers with the valid/ready logic.
- Window, column assembly and the weight register file stay in the top module.

Test Plan:
- Identity kernel (w[4]=1, others 0). Feed 3 columns with rows (10,20,30), (40,50,60), (70,80,90), all rd_zero=0 -> one result, conv_out=50, exactly 2 cycles after the last row-2 accept.
- All weights=1. Three columns of 255 with rd_zero=1 on column 0 -> conv_out=1530. Then all weights=-128 and all nine samples 255 -> conv_out=-293760 (checks width and sign).
- Continuous stream of 6 columns with out_ready=1 -> 4 results on consecutive completions, with no gaps beyond the column cadence.
- Hold out_ready=0 after the first result -> conv_out stable and in_ready drops once S1 is full. Release -> the queued results come out in order with no loss or duplication.
- Sequence row0,row2 (out of order), then row0,row1,row2 -> only one column counted. Then line_start between columns 2 and 3 -> no result until 3 new columns arrive.
- Assert rst for 1 cycle while S1 and S2 are valid -> out_valid=0 on the next cycle, no stale result afterwards, all weights read back as 0 (any window yields 0).
